// File: rtl/difftest_sched_pkg.sv
// rtl/difftest_sched_pkg.sv - shared state encoding and result codes for the difftest step scheduler
package difftest_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAIL
    } sched_state_t;

    localparam logic [7:0] SIMV_CONT = 8'h0;
    localparam logic [7:0] SIMV_DONE = 8'h1;
    localparam logic [7:0] SIMV_FAIL = 8'h2;

    // Any non-continue checker code other than "done" collapses to fail.
    function automatic logic [7:0] result_to_simv(input logic [7:0] result);
        return (result == SIMV_DONE) ? SIMV_DONE : SIMV_FAIL;
    endfunction

endpackage

// File: rtl/difftest_rr_pick.sv
// rtl/difftest_rr_pick.sv - combinational round-robin first-nonzero finder
module difftest_rr_pick #(
    parameter int NUM_CORES = 2,
    parameter int IDX_W     = 1
) (
    input  logic [NUM_CORES-1:0] mask,
    input  logic [IDX_W-1:0]     rr,
    output logic                 found,
    output logic [IDX_W-1:0]     idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            j  = (int'(rr) + k) % NUM_CORES;
            jj = IDX_W'(j);
            if (!found && mask[jj]) begin
                found = 1'b1;
                idx   = jj;
            end
        end
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// rtl/difftest_step_scheduler.sv - arbitrates per-core commit steps onto the single difftest checker port
module difftest_step_scheduler
    import difftest_sched_pkg::*;
#(
    parameter int NUM_CORES      = 2,
    parameter int STEP_WIDTH     = 8,
    parameter int ACC_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_CORES*STEP_WIDTH-1:0]  core_step,
    input  logic                             clear,
    output logic                             req_valid,
    input  logic                             req_ready,
    output logic [((NUM_CORES > 1) ? $clog2(NUM_CORES) : 1)-1:0] req_core,
    output logic [STEP_WIDTH-1:0]            req_step,
    input  logic                             rsp_valid,
    input  logic [7:0]                       rsp_result,
    output logic [7:0]                       simv_result,
    output logic [NUM_CORES-1:0]             core_stall,
    output logic                             timeout,
    output logic                             proto_err
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0]       WD_LAST    = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ACC_WIDTH-1:0]  ACC_MAX    = '1;
    localparam logic [ACC_WIDTH-1:0]  HIGH_WATER = ACC_MAX << STEP_WIDTH;
    localparam logic [STEP_WIDTH-1:0] STEP_MAX   = '1;

    sched_state_t           state;
    logic [ACC_WIDTH-1:0]   acc      [NUM_CORES];
    logic [ACC_WIDTH-1:0]   acc_next [NUM_CORES];
    logic [IDX_W-1:0]       rr;
    logic [IDX_W-1:0]       next_rr;
    logic [WD_W-1:0]        wd;
    logic [NUM_CORES-1:0]   nonzero;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [ACC_WIDTH-1:0]   pick_acc;
    logic                   issue_fire;
    logic                   clear_eff;
    logic                   all_quiet;
    logic                   wd_active;
    logic                   wd_fire;
    logic [ACC_WIDTH:0]     sum;
    logic [ACC_WIDTH:0]     sub;
    logic [ACC_WIDTH:0]     diff;

    // FAIL is terminal, so a clear there must not disturb anything.
    assign clear_eff  = clear && (state != FAIL);
    assign issue_fire = req_valid && req_ready;
    assign all_quiet  = ~|core_step;
    assign wd_active  = state inside {IDLE, ISSUE, WAIT};
    assign wd_fire    = (TIMEOUT_CYCLES != 0) && wd_active && all_quiet && !clear_eff && (wd == WD_LAST);
    assign pick_acc   = acc[pick_idx];
    assign next_rr    = (req_core == IDX_W'(NUM_CORES - 1)) ? '0 : req_core + IDX_W'(1);

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            nonzero[i]    = (acc[i] != '0);
            core_stall[i] = (acc[i] >= HIGH_WATER);
        end
    end

    difftest_rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .mask  (nonzero),
        .rr    (rr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Add and subtract land together; floor at zero covers a clear racing an issued request.
    always_comb begin
        sum  = '0;
        sub  = '0;
        diff = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum  = {1'b0, acc[i]} + (ACC_WIDTH+1)'(core_step[i*STEP_WIDTH +: STEP_WIDTH]);
            sub  = (issue_fire && (req_core == IDX_W'(i))) ? (ACC_WIDTH+1)'(req_step) : '0;
            diff = (sum > sub) ? (sum - sub) : '0;
            if (clear_eff) begin
                acc_next[i] = '0;
            end else if (diff > {1'b0, ACC_MAX}) begin
                acc_next[i] = ACC_MAX;
            end else begin
                acc_next[i] = diff[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CORES; i++) begin
            acc[i] <= reset ? '0 : acc_next[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr          <= '0;
            wd          <= '0;
            req_valid   <= 1'b0;
            req_core    <= '0;
            req_step    <= '0;
            simv_result <= SIMV_CONT;
            timeout     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (rsp_valid && (state != WAIT)) begin
                proto_err <= 1'b1;
            end

            if (clear_eff || !all_quiet) begin
                wd <= '0;
            end else if (wd_active) begin
                wd <= wd + WD_W'(1);
            end

            if (wd_fire) begin
                state       <= FAIL;
                req_valid   <= 1'b0;
                simv_result <= SIMV_FAIL;
                timeout     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (pick_found) begin
                            req_core  <= pick_idx;
                            req_step  <= (pick_acc > ACC_WIDTH'(STEP_MAX)) ? STEP_MAX
                                                                          : pick_acc[STEP_WIDTH-1:0];
                            req_valid <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (req_ready) begin
                            req_valid <= 1'b0;
                            rr        <= next_rr;
                            state     <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (rsp_valid) begin
                            if (rsp_result == SIMV_CONT) begin
                                state <= IDLE;
                            end else begin
                                state       <= (rsp_result == SIMV_DONE) ? DONE : FAIL;
                                simv_result <= result_to_simv(rsp_result);
                            end
                        end
                    end
                    DONE: begin
                        if (clear) begin
                            state       <= IDLE;
                            simv_result <= SIMV_CONT;
                        end
                    end
                    FAIL: begin
                        state <= FAIL;
                    end
                    default: begin
                        state <= FAIL;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// tb/tb_difftest_step_scheduler.sv - self-checking bench for difftest_step_scheduler
module tb_difftest_step_scheduler;

    localparam int N        = 2;
    localparam int SW       = 8;
    localparam int TO       = 40;
    localparam int ACC_CAP  = 65535;
    localparam int HWM      = 65280;
    localparam int STEP_CAP = 255;
    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_DONE = 3, M_FAIL = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main two-core instance
    logic            reset, clear, req_ready, rsp_valid;
    logic [7:0]      rsp_result;
    logic [7:0]      step_in [N];
    logic [N*SW-1:0] core_step;
    logic            req_valid, timeout, proto_err;
    logic [0:0]      req_core;
    logic [7:0]      req_step, simv_result;
    logic [N-1:0]    core_stall;

    assign core_step = {step_in[1], step_in[0]};

    difftest_step_scheduler #(
        .NUM_CORES(N), .STEP_WIDTH(SW), .ACC_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clock(clock), .reset(reset), .core_step(core_step), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core), .req_step(req_step),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .simv_result(simv_result),
        .core_stall(core_stall), .timeout(timeout), .proto_err(proto_err)
    );

    // single-core instance with a short watchdog
    logic       o_reset, o_clear, o_ready, o_rsp_valid;
    logic [7:0] o_rsp_result, o_step;
    logic       o_req_valid, o_timeout, o_proto;
    logic [0:0] o_req_core, o_stall;
    logic [7:0] o_req_step, o_simv;

    difftest_step_scheduler #(
        .NUM_CORES(1), .STEP_WIDTH(SW), .ACC_WIDTH(16), .TIMEOUT_CYCLES(10)
    ) u_one (
        .clock(clock), .reset(o_reset), .core_step(o_step), .clear(o_clear),
        .req_valid(o_req_valid), .req_ready(o_ready), .req_core(o_req_core), .req_step(o_req_step),
        .rsp_valid(o_rsp_valid), .rsp_result(o_rsp_result), .simv_result(o_simv),
        .core_stall(o_stall), .timeout(o_timeout), .proto_err(o_proto)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference model: spec-level view of the scheduler
    int m_state, m_rr, m_core, m_step, m_wd, m_simv;
    bit m_valid, m_timeout, m_proto;
    int m_acc [N];
    int grant_core [$];
    int grant_step [$];

    task automatic model_reset();
        m_state = M_IDLE; m_rr = 0; m_core = 0; m_step = 0; m_wd = 0; m_simv = 0;
        m_valid = 0; m_timeout = 0; m_proto = 0;
        for (int i = 0; i < N; i++) m_acc[i] = 0;
    endtask

    task automatic model_next();
        int  nxt [N];
        int  v, c;
        bit  hs, clr, quiet, fire, got;
        if (reset) begin
            model_reset();
        end else begin
            hs    = (m_state == M_ISSUE) && req_ready;
            clr   = clear && (m_state != M_FAIL);
            quiet = 1;
            for (int i = 0; i < N; i++) if (step_in[i] != 0) quiet = 0;
            for (int i = 0; i < N; i++) begin
                v = m_acc[i] + int'(step_in[i]) - ((hs && m_core == i) ? m_step : 0);
                if (v < 0) v = 0;
                if (v > ACC_CAP) v = ACC_CAP;
                nxt[i] = clr ? 0 : v;
            end
            fire = 0;
            if (clr || !quiet) m_wd = 0;
            else if (m_state == M_IDLE || m_state == M_ISSUE || m_state == M_WAIT) begin
                m_wd++;
                fire = (m_wd == TO);
            end
            if (rsp_valid && m_state != M_WAIT) m_proto = 1;
            if (fire) begin
                m_state = M_FAIL; m_simv = 2; m_timeout = 1; m_valid = 0;
            end else begin
                case (m_state)
                    M_IDLE: begin
                        got = 0;
                        for (int k = 0; k < N; k++) begin
                            c = (m_rr + k) % N;
                            if (!got && m_acc[c] != 0) begin
                                got = 1; m_core = c;
                                m_step = (m_acc[c] > STEP_CAP) ? STEP_CAP : m_acc[c];
                                m_valid = 1; m_state = M_ISSUE;
                            end
                        end
                    end
                    M_ISSUE: if (req_ready) begin
                        m_rr = (m_core + 1) % N; m_valid = 0; m_state = M_WAIT;
                    end
                    M_WAIT: if (rsp_valid) begin
                        if (rsp_result == 0) m_state = M_IDLE;
                        else if (rsp_result == 1) begin m_state = M_DONE; m_simv = 1; end
                        else begin m_state = M_FAIL; m_simv = 2; end
                    end
                    M_DONE: if (clear) begin m_state = M_IDLE; m_simv = 0; end
                    default: ;
                endcase
            end
            for (int i = 0; i < N; i++) m_acc[i] = nxt[i];
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] e_stall;
        for (int i = 0; i < N; i++) e_stall[i] = (m_acc[i] >= HWM);
        check("req_valid", req_valid, m_valid);
        if (m_valid) begin
            check("req_core", req_core, m_core);
            check("req_step", req_step, m_step);
        end
        check("simv_result", simv_result, m_simv);
        check("core_stall", core_stall, e_stall);
        check("timeout", timeout, m_timeout);
        check("proto_err", proto_err, m_proto);
    endtask

    task automatic tick();
        if (req_valid && req_ready) begin
            grant_core.push_back(int'(req_core));
            grant_step.push_back(int'(req_step));
        end
        model_next();
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) step_in[i] = 8'd0;
        clear = 0; req_ready = 0; rsp_valid = 0; rsp_result = 8'd0;
    endtask

    task automatic main_reset();
        idle_inputs();
        reset = 1; tick(); reset = 0;
        grant_core.delete(); grant_step.delete();
    endtask

    task automatic tick1();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int r, quiet;
        idle_inputs();
        reset = 1;
        o_reset = 1; o_clear = 0; o_ready = 0; o_rsp_valid = 0; o_rsp_result = 8'd0; o_step = 8'd0;
        model_reset();
        @(negedge clock);
        tick();
        check("rst_req_step", req_step, 0);
        check("rst_req_core", req_core, 0);
        reset = 0;

        // both cores stepping 3 every cycle: grants alternate
        main_reset();
        for (int n = 0; n < 30; n++) begin
            step_in[0] = 8'd3; step_in[1] = 8'd3; req_ready = 1;
            rsp_valid = (m_state == M_WAIT); rsp_result = 8'd0;
            tick();
        end
        check("alt_grant_count_ok", grant_core.size() >= 4, 1);
        for (int k = 0; k < 4 && k < grant_core.size(); k++) check("alt_grant", grant_core[k], k % 2);

        // 700 steps on core 0 drain as 255, 255, 190
        main_reset();
        for (int n = 0; n < 20; n++) begin
            step_in[0] = (n == 0 || n == 1) ? 8'd255 : (n == 2) ? 8'd190 : 8'd0;
            step_in[1] = 8'd0; req_ready = 1;
            rsp_valid = (m_state == M_WAIT); rsp_result = 8'd0;
            tick();
        end
        check("split_count", grant_step.size(), 3);
        if (grant_step.size() == 3) begin
            check("split_0", grant_step[0], 255);
            check("split_1", grant_step[1], 255);
            check("split_2", grant_step[2], 190);
        end

        // high-water and saturation on core 0 while the checker stalls
        main_reset();
        step_in[0] = 8'd255;
        for (int n = 0; n < 255; n++) tick();
        check("stall_below_hw", core_stall[0], 0);
        tick();
        check("stall_at_hw", core_stall[0], 1);
        for (int n = 0; n < 4; n++) tick();
        step_in[0] = 8'd0;
        for (int n = 0; n < 12; n++) begin
            req_ready = 1; rsp_valid = (m_state == M_WAIT); rsp_result = 8'd0;
            tick();
        end

        // randomized traffic against the model
        main_reset();
        quiet = 0;
        for (int n = 0; n < 3000; n++) begin
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 299) == 0) quiet = 45;
            for (int i = 0; i < N; i++)
                step_in[i] = (quiet > 0 || $urandom_range(0, 2) == 0) ? 8'd0
                           : 8'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 255 : 4));
            req_ready = ($urandom_range(0, 2) != 0);
            rsp_valid = (m_state == M_WAIT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 499) == 0);
            r = $urandom_range(0, 99);
            rsp_result = (r < 88) ? 8'd0 : (r < 95) ? 8'd1 : (r < 98) ? 8'd2 : 8'($urandom_range(3, 255));
            clear = (m_state == M_DONE) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 149) == 0);
            reset = (m_state == M_FAIL) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 999) == 0);
            tick();
        end
        idle_inputs();
        reset = 1;

        // single-core instance: latency and drain
        tick1(); o_reset = 0;
        check("one_rst_valid", o_req_valid, 0);
        check("one_rst_simv", o_simv, 0);
        check("one_rst_timeout", o_timeout, 0);
        check("one_rst_proto", o_proto, 0);
        check("one_rst_stall", o_stall, 0);
        o_step = 8'd5; tick1();
        check("one_lat_early", o_req_valid, 0);
        o_step = 8'd0; tick1();
        check("one_lat_valid", o_req_valid, 1);
        check("one_lat_core", o_req_core, 0);
        check("one_lat_step", o_req_step, 5);
        o_ready = 1; tick1(); o_ready = 0;
        check("one_wait_valid", o_req_valid, 0);
        o_rsp_valid = 1; o_rsp_result = 8'd0; tick1(); o_rsp_valid = 0;
        tick1(); tick1();
        check("one_drained", o_req_valid, 0);
        check("one_no_proto", o_proto, 0);

        // done, clear, fail
        o_step = 8'd2; tick1(); o_step = 8'd0; tick1();
        o_ready = 1; tick1(); o_ready = 0;
        o_rsp_valid = 1; o_rsp_result = 8'd1; tick1(); o_rsp_valid = 0;
        check("done_simv", o_simv, 1);
        o_step = 8'd9; tick1(); tick1(); tick1();
        check("done_no_req", o_req_valid, 0);
        o_step = 8'd0; o_clear = 1; tick1(); o_clear = 0;
        check("clear_simv", o_simv, 0);
        tick1(); tick1();
        check("clear_acc", o_req_valid, 0);
        o_step = 8'd1; tick1(); o_step = 8'd0; tick1();
        o_ready = 1; tick1(); o_ready = 0;
        o_rsp_valid = 1; o_rsp_result = 8'd7; tick1(); o_rsp_valid = 0;
        check("fail_simv", o_simv, 2);
        check("fail_not_timeout", o_timeout, 0);
        o_clear = 1; tick1(); o_clear = 0; tick1();
        check("fail_sticky", o_simv, 2);

        // watchdog fires on the tenth quiet cycle
        o_reset = 1; tick1(); o_reset = 0;
        repeat (9) tick1();
        check("wd_before", o_simv, 0);
        check("wd_before_to", o_timeout, 0);
        tick1();
        check("wd_fire_simv", o_simv, 2);
        check("wd_fire_to", o_timeout, 1);

        // a step on cycle 9 restarts the count
        o_reset = 1; tick1(); o_reset = 0;
        repeat (8) tick1();
        o_step = 8'd1; tick1(); o_step = 8'd0;
        tick1();
        check("wd_restart", o_simv, 0);
        repeat (8) tick1();
        check("wd_restart_hold", o_simv, 0);
        tick1();
        check("wd_restart_fire", o_simv, 2);
        check("wd_restart_to", o_timeout, 1);
        check("wd_drop_valid", o_req_valid, 0);

        // stray response in IDLE
        o_reset = 1; tick1(); o_reset = 0;
        o_rsp_valid = 1; o_rsp_result = 8'd1; tick1(); o_rsp_valid = 0;
        check("proto_set", o_proto, 1);
        check("proto_no_done", o_simv, 0);
        o_step = 8'd3; tick1(); o_step = 8'd0; tick1();
        check("proto_still_idle", o_req_valid, 1);
        check("proto_step", o_req_step, 3);

        // reset while waiting for a response
        o_ready = 1; tick1(); o_ready = 0;
        o_reset = 1; tick1(); o_reset = 0;
        check("rst_wait_valid", o_req_valid, 0);
        check("rst_wait_step", o_req_step, 0);
        check("rst_wait_simv", o_simv, 0);
        check("rst_wait_proto", o_proto, 0);
        check("rst_wait_to", o_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
